dac_frame_scheduler: RTL and testbench

- Shares the single 16-bit SPI DAC serializer between NUM_CH tone sample sources.
- Generates the DAC sample-rate tick and grants one enabled channel per tick, round-robin.
- Hands the chosen sample to the serializer with a start/busy handshake.
- Publishes the last transmitted sample and channel for the HEX/LED display path. Sits between the tone channels and the DAC SPI serializer.

---
 rtl/dac_pkg.sv | 16 +
 rtl/dac_frame_scheduler_rr_arbiter.sv | 33 +++
 rtl/dac_frame_scheduler.sv | 139 +++++++++++++
 tb/tb_dac_frame_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC frame scheduler.
// State encoding, "no channel" index and default midscale word.
package dac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } state_e;

    localparam int          CH_W         = 3;
    localparam logic [2:0]  NO_CH        = 3'd7;
    localparam logic [15:0] MIDSCALE_DEF = 16'h8000;

endpackage

// File: rtl/dac_frame_scheduler_rr_arbiter.sv
// Round-robin search: first set mask bit strictly after ptr_i, wrapping.
// Ports: mask_i, ptr_i in; grant_o (index), found_o out. Combinational.
module rr_arbiter
    import dac_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic [CH_W-1:0]   grant_o,
    output logic              found_o
);

    logic [CH_W-1:0]   idx;
    logic [NUM_CH-1:0] sh;

    // k runs 1..NUM_CH so the current pointer is checked last.
    always_comb begin
        grant_o = '0;
        found_o = 1'b0;
        idx     = '0;
        sh      = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = CH_W'((int'(ptr_i) + k) % NUM_CH);
            sh  = mask_i >> idx;
            if (!found_o && sh[0]) begin
                found_o = 1'b1;
                grant_o = idx;
            end
        end
    end

endmodule

// File: rtl/dac_frame_scheduler.sv
// Shares one SPI DAC serializer between NUM_CH sources, one grant per tick.
// Ports: clock/reset_n; ch_en/ch_data/ch_valid/ch_ack to sources;
// ser_data/ser_start/ser_busy to serializer; disp_data/disp_ch,
// underrun/overrun status pulses.
module dac_frame_scheduler
    import dac_pkg::*;
#(
    parameter int                NUM_CH   = 4,
    parameter int                DATA_W   = 16,
    parameter int                RATE_DIV = 2500,
    parameter logic [DATA_W-1:0] MIDSCALE = DATA_W'(MIDSCALE_DEF)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]        ch_valid,
    output logic [NUM_CH-1:0]        ch_ack,
    output logic [DATA_W-1:0]        ser_data,
    output logic                     ser_start,
    input  logic                     ser_busy,
    output logic [DATA_W-1:0]        disp_data,
    output logic [2:0]               disp_ch,
    output logic                     underrun,
    output logic                     overrun
);

    localparam int CNT_W = $clog2(RATE_DIV);

    logic [NUM_CH-1:0]        en_s1_q, en_s2_q;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     tick_q, tick_d;
    state_e                   state_q, state_d;
    logic [CH_W-1:0]          ptr_q, ptr_d;
    logic [DATA_W-1:0]        word_q, word_d;
    logic [2:0]               chan_q, chan_d;
    logic [NUM_CH*DATA_W-1:0] hold_q, hold_d;
    logic                     first_q, first_d;

    logic [CH_W-1:0]          grant;
    logic                     found;
    logic [NUM_CH-1:0]        vsh;
    logic [DATA_W-1:0]        sel_data, sel_hold;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .mask_i (en_s2_q),
        .ptr_i  (ptr_q),
        .grant_o(grant),
        .found_o(found)
    );

    assign vsh       = ch_valid >> grant;
    assign sel_data  = ch_data[int'(grant)*DATA_W +: DATA_W];
    assign sel_hold  = hold_q[int'(grant)*DATA_W +: DATA_W];
    assign ser_data  = word_q;
    assign disp_data = word_q;
    assign disp_ch   = chan_q;

    always_comb begin
        cnt_d  = (cnt_q == CNT_W'(RATE_DIV - 1)) ? '0 : cnt_q + 1'b1;
        tick_d = (cnt_q == CNT_W'(RATE_DIV - 1));
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        word_d    = word_q;
        chan_d    = chan_q;
        hold_d    = hold_q;
        first_d   = first_q;
        ch_ack    = '0;
        underrun  = 1'b0;
        ser_start = 1'b0;
        // Ticks are never queued; one arriving mid-frame is just flagged.
        overrun   = tick_q && (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (tick_q) state_d = ARB;
            end
            ARB: begin
                state_d = START;
                if (!found) begin
                    word_d = MIDSCALE;
                    chan_d = NO_CH;
                end else if (vsh[0]) begin
                    word_d = sel_data;
                    chan_d = 3'(grant);
                    ptr_d  = grant;
                    ch_ack = NUM_CH'(1) << grant;
                    hold_d[int'(grant)*DATA_W +: DATA_W] = sel_data;
                end else begin
                    // Stale source: repeat its last word.
                    word_d   = sel_hold;
                    chan_d   = 3'(grant);
                    ptr_d    = grant;
                    underrun = 1'b1;
                end
            end
            START: begin
                ser_start = 1'b1;
                first_d   = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                // Busy only rises a cycle after start; skip that cycle.
                first_d = 1'b0;
                if (!first_q && !ser_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            en_s1_q <= '0;
            en_s2_q <= '0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            state_q <= IDLE;
            ptr_q   <= CH_W'(NUM_CH - 1);
            word_q  <= MIDSCALE;
            chan_q  <= NO_CH;
            hold_q  <= {NUM_CH{MIDSCALE}};
            first_q <= 1'b0;
        end else begin
            en_s1_q <= ch_en;
            en_s2_q <= en_s1_q;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            state_q <= state_d;
            ptr_q   <= ptr_d;
            word_q  <= word_d;
            chan_q  <= chan_d;
            hold_q  <= hold_d;
            first_q <= first_d;
        end
    end

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Scoreboard bench for dac_frame_scheduler with a behavioural model.
// Stimulus pushes expected frames; a monitor checks each ser_start.
module tb_dac_frame_scheduler;

    localparam int RD = 20;

    typedef struct {
        logic [15:0] word;
        logic [2:0]  chan;
        logic [3:0]  ack;
        logic        ur;
        int          gap;
        int          ovr;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  ch_en;
    logic [63:0] ch_data;
    logic [3:0]  ch_valid;
    logic [3:0]  ch_ack;
    logic [15:0] ser_data;
    logic        ser_start;
    logic        ser_busy;
    logic [15:0] disp_data;
    logic [2:0]  disp_ch;
    logic        underrun;
    logic        overrun;

    exp_t        q[$];
    int          total = 0;
    int          passed = 0;
    int          cyc = 0;
    int          last = 0;
    int          ovr_cnt = 0;
    logic [3:0]  prev_ack = '0;
    logic        prev_ur = 1'b0;
    int          left = 0;
    int          next_len = 10;
    int          prev_len = -1;
    int          m_ptr = 3;
    logic [15:0] m_hold[4];

    always #5 clock = ~clock;

    dac_frame_scheduler #(
        .NUM_CH(4), .DATA_W(16), .RATE_DIV(RD), .MIDSCALE(16'h8000)
    ) dut (
        .clock(clock), .reset_n(reset_n), .ch_en(ch_en),
        .ch_data(ch_data), .ch_valid(ch_valid), .ch_ack(ch_ack),
        .ser_data(ser_data), .ser_start(ser_start), .ser_busy(ser_busy),
        .disp_data(disp_data), .disp_ch(disp_ch),
        .underrun(underrun), .overrun(overrun)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    // Serializer: busy for next_len cycles starting the cycle after start.
    always @(negedge clock) begin
        if (!reset_n) begin
            left     = 0;
            ser_busy = 1'b0;
        end else begin
            ser_busy = (left > 0);
            if (left > 0) left--;
            if (ser_start) left = next_len;
        end
    end

    // Monitor: pops one expectation per ser_start.
    always @(negedge clock) begin
        exp_t e;
        cyc++;
        if (!reset_n) begin
            last     = cyc;
            ovr_cnt  = 0;
            prev_ack = '0;
            prev_ur  = 1'b0;
        end else begin
            if (ser_start) begin
                if (q.size() == 0) begin
                    chk("unexpected_start", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("ser_data", 32'(ser_data), 32'(e.word));
                    chk("disp_data", 32'(disp_data), 32'(e.word));
                    chk("disp_ch", 32'(disp_ch), 32'(e.chan));
                    chk("ch_ack", 32'(prev_ack), 32'(e.ack));
                    chk("underrun", 32'(prev_ur), 32'(e.ur));
                    chk("start_gap", 32'(cyc - last), 32'(e.gap));
                    chk("overruns", 32'(ovr_cnt), 32'(e.ovr));
                end
                last    = cyc;
                ovr_cnt = 0;
            end
            if (overrun) ovr_cnt++;
            prev_ack = ch_ack;
            prev_ur  = underrun;
        end
    end

    task automatic finish_up();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    endtask

    task automatic wait_start();
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clock);
            if (ser_start) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            $display("FAIL start_timeout: got none want ser_start");
            finish_up();
        end
        #1;
    endtask

    task automatic model_reset();
        m_ptr    = 3;
        prev_len = -1;
        for (int i = 0; i < 4; i++) m_hold[i] = 16'h8000;
    endtask

    task automatic chk_reset_outs();
        chk("rst_ser_data", 32'(ser_data), 32'h8000);
        chk("rst_disp_data", 32'(disp_data), 32'h8000);
        chk("rst_disp_ch", 32'(disp_ch), 32'd7);
        chk("rst_ser_start", 32'(ser_start), 32'd0);
        chk("rst_ch_ack", 32'(ch_ack), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
    endtask

    // One frame: drive inputs, predict the next issued word, await it.
    // late=1 changes ch_en one cycle before the coming arbitration.
    task automatic frame(input logic [3:0] en, input logic [3:0] vld,
                         input logic [63:0] dw, input int len,
                         input bit late);
        exp_t       e;
        logic [3:0] used;
        logic [1:0] idx, gi;
        bit         found;
        int         k;
        used = late ? ch_en : en;
        if (!late) ch_en = en;
        ch_valid = vld;
        ch_data  = dw;
        found = 1'b0;
        gi    = '0;
        for (int s = 1; s <= 4; s++) begin
            idx = 2'((m_ptr + s) % 4);
            if (!found && used[idx]) begin
                found = 1'b1;
                gi    = idx;
            end
        end
        e.ack = '0;
        e.ur  = 1'b0;
        if (!found) begin
            e.word = 16'h8000;
            e.chan = 3'd7;
        end else if (vld[gi]) begin
            e.word     = dw[int'(gi)*16 +: 16];
            m_hold[gi] = e.word;
            e.chan     = 3'(gi);
            e.ack      = 4'b0001 << gi;
            m_ptr      = int'(gi);
        end else begin
            e.word = m_hold[gi];
            e.chan = 3'(gi);
            e.ur   = 1'b1;
            m_ptr  = int'(gi);
        end
        if (prev_len < 0) begin
            e.gap = RD + 2;
            e.ovr = 0;
        end else begin
            // Ticks land RD-2, 2RD-2, ... after the previous start; the
            // first one after the serializer frees up is taken.
            k = 0;
            while (RD - 2 + RD * k < prev_len + 2) k++;
            e.gap = RD * (k + 1);
            e.ovr = k;
        end
        q.push_back(e);
        prev_len = len;
        next_len = len;
        if (late) begin
            repeat (RD - 2) @(negedge clock);
            #1;
            ch_en = en;
        end
        wait_start();
    endtask

    initial begin
        logic [63:0] dw;
        logic [3:0]  en;
        int          len;
        bit          late;
        reset_n  = 1'b0;
        ch_en    = '0;
        ch_valid = '0;
        ch_data  = '0;
        ser_busy = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        #1;
        chk_reset_outs();
        @(negedge clock);
        #1;
        reset_n = 1'b1;
        frame(4'b0000, 4'b0000, 64'h0, 10, 1'b0);

        dw = {16'h4000, 16'h3000, 16'h2000, 16'h1000};
        repeat (5) frame(4'b1111, 4'b1111, dw, 10, 1'b0);

        frame(4'b0101, 4'b1111, dw, 10, 1'b0);
        frame(4'b0101, 4'b1111, dw, 10, 1'b0);
        dw = {16'h4000, 16'h3abc, 16'h2000, 16'h1000};
        frame(4'b0101, 4'b1011, dw, 10, 1'b0);

        frame(4'b1111, 4'b1111, dw, 25, 1'b0);
        frame(4'b1111, 4'b1111, dw, 10, 1'b0);
        frame(4'b1111, 4'b1111, dw, 16, 1'b0);
        frame(4'b1111, 4'b1111, dw, 10, 1'b0);

        frame(4'b1000, 4'b1111, dw, 10, 1'b1);
        frame(4'b1000, 4'b1111, dw, 10, 1'b0);

        repeat (3) @(negedge clock);
        #1;
        chk("queue_before_reset", 32'(q.size()), 32'd0);
        reset_n = 1'b0;
        #1;
        chk_reset_outs();
        repeat (2) @(negedge clock);
        #1;
        reset_n = 1'b1;
        model_reset();
        frame(4'b1111, 4'b1111, dw, 10, 1'b0);

        for (int n = 0; n < 30; n++) begin
            en = 4'($urandom_range(0, 15));
            dw = {16'($urandom), 16'($urandom),
                  16'($urandom), 16'($urandom)};
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(17, 45)
                                               : $urandom_range(1, 16);
            late = ($urandom_range(0, 3) == 0) &&
                   (prev_len >= 1) && (prev_len <= RD - 4);
            frame(en, 4'($urandom_range(0, 15)), dw, len, late);
        end

        repeat (5) @(negedge clock);
        chk("queue_empty", 32'(q.size()), 32'd0);
        finish_up();
    end

endmodule
